// File: rtl/exec_pkg.sv
// Shared opcode/state encodings and instruction field positions for the
// exec_sequencer slice.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLT  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ADDI = 4'h9,
        OP_LI   = 4'hA
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_LSB = 9;
    localparam int unsigned RS_LSB = 6;
    localparam int unsigned RT_LSB = 3;

endpackage

// File: rtl/exec_sequencer_alu8.sv
// Combinational 8-bit ALU: wrap-around arithmetic, carry/borrow flag and
// illegal-opcode detection for opcodes B-F.
module alu8
    import exec_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm,
    output logic [7:0] y,
    output logic       carry,
    output logic       illegal
);

    logic [7:0] imm6_sx;
    logic [8:0] sum;

    assign imm6_sx = {{2{imm[5]}}, imm[5:0]};

    always_comb begin
        y       = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        sum     = '0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[7:0];
                carry = sum[8];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {7'd0, ($signed(a) < $signed(b))};
            OP_SHL:  y = a << b[2:0];
            OP_SHR:  y = a >> b[2:0];
            OP_ADDI: begin
                sum   = {1'b0, a} + {1'b0, imm6_sx};
                y     = sum[7:0];
                carry = sum[8];
            end
            OP_LI:   y = imm;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Four-state instruction sequencer around an external 8x8 register file:
// accept, read operands, execute, write back.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_read1,
    output logic [2:0]  rf_read2,
    input  logic [7:0]  rf_data1,
    input  logic [7:0]  rf_data2,
    output logic [2:0]  rf_write_reg,
    output logic [7:0]  rf_write_data,
    output logic        rf_reg_write,
    output logic        done,
    output logic [7:0]  result,
    output logic        zero,
    output logic        carry,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  alu_res_q, alu_res_d;
    logic        alu_c_q, alu_c_d;
    logic [7:0]  result_q, result_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic        illegal_q, illegal_d;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [7:0]  alu_y;
    logic        alu_carry;
    logic        alu_illegal;

    assign op = instr_q[OP_LSB +: 4];
    assign rd = instr_q[RD_LSB +: 3];

    // Read addresses come straight from the latched word, so they are held
    // stable from the accept edge through EXEC.
    assign rf_read1 = instr_q[RS_LSB +: 3];
    assign rf_read2 = instr_q[RT_LSB +: 3];

    assign result  = result_q;
    assign zero    = zero_q;
    assign carry   = carry_q;
    assign illegal = illegal_q;

    alu8 u_alu (
        .op      (op),
        .a       (rf_data1),
        .b       (rf_data2),
        .imm     (instr_q[7:0]),
        .y       (alu_y),
        .carry   (alu_carry),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            alu_res_q <= '0;
            alu_c_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_res_q <= alu_res_d;
            alu_c_q   <= alu_c_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end

    // Write-port outputs are decoded from state so an async reset drops
    // rf_reg_write immediately and aborts a write in flight.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        alu_res_d     = alu_res_q;
        alu_c_d       = alu_c_q;
        result_d      = result_q;
        zero_d        = zero_q;
        carry_d       = carry_q;
        illegal_d     = illegal_q;
        instr_ready   = 1'b0;
        done          = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_reg_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                alu_res_d = alu_y;
                alu_c_d   = alu_carry;
                if (alu_illegal || (op == OP_NOP)) begin
                    done      = 1'b1;
                    result_d  = alu_y;
                    zero_d    = (alu_y == '0);
                    carry_d   = alu_carry;
                    illegal_d = alu_illegal;
                    state_d   = (alu_illegal && ILLEGAL_HALT) ? S_HALT : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_write_reg  = rd;
                rf_write_data = alu_res_q;
                rf_reg_write  = (rd != '0);
                done          = 1'b1;
                result_d      = alu_res_q;
                zero_d        = (alu_res_q == '0);
                carry_d       = alu_c_q;
                illegal_d     = 1'b0;
                state_d       = S_IDLE;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: register-file model, table of instructions with
// hand-computed results, scoreboard queue, and reset/halt corner sequences.
`timescale 1ns/1ps
module tb_exec_sequencer;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  res;
        logic        z;
        logic        c;
        logic        ill;
        logic        wr;
        logic        chk_res;
        int          lat;
        int          acc;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [2:0]  rf_read1, rf_read2, rf_write_reg;
    logic [7:0]  rf_data1 = '0, rf_data2 = '0;
    logic [7:0]  rf_write_data, result;
    logic        rf_reg_write, done, zero, carry, illegal;

    logic        h_valid = 1'b0;
    logic [15:0] h_instr = '0;
    logic [7:0]  h_data1 = '0, h_data2 = '0;
    logic        h_ready, h_reg_write, h_done, h_zero, h_carry, h_illegal;
    logic [2:0]  h_read1, h_read2, h_write_reg;
    logic [7:0]  h_write_data, h_result;

    logic [7:0]  rf [8] = '{default: 8'h00};
    int          cyc = 0;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    vec_t        exp_q[$];
    vec_t        vt[26];
    bit          pend = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) if (rf_reg_write) rf[rf_write_reg] <= rf_write_data;
    always @(negedge clock) begin
        rf_data1 <= rf[rf_read1];
        rf_data2 <= rf[rf_read2];
    end

    exec_sequencer #(.ILLEGAL_HALT(1'b0)) u_dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_data1(rf_data1),
        .rf_data2(rf_data2), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_reg_write(rf_reg_write), .done(done), .result(result), .zero(zero),
        .carry(carry), .illegal(illegal)
    );

    exec_sequencer #(.ILLEGAL_HALT(1'b1)) u_halt (
        .clock(clock), .reset(reset), .instr_valid(h_valid), .instr_ready(h_ready),
        .instr(h_instr), .rf_read1(h_read1), .rf_read2(h_read2), .rf_data1(h_data1),
        .rf_data2(h_data2), .rf_write_reg(h_write_reg), .rf_write_data(h_write_data),
        .rf_reg_write(h_reg_write), .done(h_done), .result(h_result), .zero(h_zero),
        .carry(h_carry), .illegal(h_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd, input logic [7:0] imm);
        return {4'hA, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] addi(input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] imm);
        return {4'h9, rd, rs, imm};
    endfunction

    function automatic vec_t mk(input logic [15:0] i, input logic [7:0] r, input logic z, input logic c,
                                input logic ill, input logic wr, input logic chk, input int lat);
        vec_t v;
        v.instr = i; v.res = r; v.z = z; v.c = c; v.ill = ill;
        v.wr = wr; v.chk_res = chk; v.lat = lat; v.acc = 0;
        return v;
    endfunction

    task automatic send(input vec_t v, input bit push);
        int unsigned w = 0;
        @(negedge clock);
        while (!instr_ready && w < 60) begin
            @(negedge clock);
            w++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'(instr_ready), 32'd1);
            return;
        end
        instr_valid = 1'b1;
        instr = v.instr;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr = 16'hFFFF;
        if (push) begin
            v.acc = cyc;
            exp_q.push_back(v);
        end
    endtask

    task automatic drain();
        int unsigned w = 0;
        while ((exp_q.size() != 0 || pend) && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: pop on done, status outputs compared one negedge later
    // because they update on the retiring edge.
    initial begin
        vec_t cur;
        bit wr_seen = 1'b0;
        logic [2:0] wr_reg = '0;
        logic [7:0] wr_data = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                wr_seen = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cur.chk_res) begin
                        check("result", 32'(result), 32'(cur.res));
                        check("zero", 32'(zero), 32'(cur.z));
                        check("carry", 32'(carry), 32'(cur.c));
                    end
                    check("illegal", 32'(illegal), 32'(cur.ill));
                    pend = 1'b0;
                end
                if (rf_reg_write) begin
                    wr_seen = 1'b1;
                    wr_reg = rf_write_reg;
                    wr_data = rf_write_data;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                        check("write_en", 32'(wr_seen), 32'(cur.wr));
                        if (cur.wr) begin
                            check("write_reg", 32'(wr_reg), 32'(cur.instr[11:9]));
                            check("write_data", 32'(wr_data), 32'(cur.res));
                        end
                        pend = 1'b1;
                    end
                    wr_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        bit seen;

        vt[0]  = mk(li(3'd1, 8'h7F),         8'h7F, 0, 0, 0, 1, 1, 3);
        vt[1]  = mk(li(3'd2, 8'h01),         8'h01, 0, 0, 0, 1, 1, 3);
        vt[2]  = mk(enc(4'h1, 3, 1, 2),      8'h80, 0, 0, 0, 1, 1, 3);
        vt[3]  = mk(li(3'd1, 8'hFF),         8'hFF, 0, 0, 0, 1, 1, 3);
        vt[4]  = mk(addi(3'd2, 3'd1, 6'h01), 8'h00, 1, 1, 0, 1, 1, 3);
        vt[5]  = mk(enc(4'h2, 3, 0, 1),      8'h01, 0, 1, 0, 1, 1, 3);
        vt[6]  = mk(li(3'd1, 8'h80),         8'h80, 0, 0, 0, 1, 1, 3);
        vt[7]  = mk(li(3'd2, 8'h01),         8'h01, 0, 0, 0, 1, 1, 3);
        vt[8]  = mk(enc(4'h6, 3, 1, 2),      8'h01, 0, 0, 0, 1, 1, 3);
        vt[9]  = mk(li(3'd4, 8'h81),         8'h81, 0, 0, 0, 1, 1, 3);
        vt[10] = mk(li(3'd5, 8'h01),         8'h01, 0, 0, 0, 1, 1, 3);
        vt[11] = mk(enc(4'h7, 6, 4, 5),      8'h02, 0, 0, 0, 1, 1, 3);
        vt[12] = mk(li(3'd5, 8'h07),         8'h07, 0, 0, 0, 1, 1, 3);
        vt[13] = mk(enc(4'h8, 6, 4, 5),      8'h01, 0, 0, 0, 1, 1, 3);
        vt[14] = mk(enc(4'h1, 0, 1, 2),      8'h81, 0, 0, 0, 0, 1, 3);
        vt[15] = mk(enc(4'h3, 7, 4, 1),      8'h80, 0, 0, 0, 1, 1, 3);
        vt[16] = mk(enc(4'h5, 7, 4, 4),      8'h00, 1, 0, 0, 1, 1, 3);
        vt[17] = mk(enc(4'h4, 7, 5, 1),      8'h87, 0, 0, 0, 1, 1, 3);
        vt[18] = mk(enc(4'h1, 7, 4, 4),      8'h02, 0, 1, 0, 1, 1, 3);
        vt[19] = mk(enc(4'h2, 7, 5, 4),      8'h86, 0, 1, 0, 1, 1, 3);
        vt[20] = mk(addi(3'd7, 3'd4, 6'h3E), 8'h7F, 0, 1, 0, 1, 1, 3);
        vt[21] = mk(enc(4'h6, 7, 2, 1),      8'h00, 1, 0, 0, 1, 1, 3);
        vt[22] = mk(16'h0A00,                8'h00, 0, 0, 0, 0, 0, 2);
        vt[23] = mk(16'hCE00,                8'h00, 0, 0, 1, 0, 0, 2);
        vt[24] = mk(li(3'd0, 8'h00),         8'h00, 1, 0, 0, 0, 1, 3);
        vt[25] = mk(enc(4'h1, 3, 1, 2),      8'h81, 0, 0, 0, 1, 1, 3);

        #23;
        check("reset_outputs",
              32'({instr_ready, rf_read1, rf_read2, rf_write_reg, rf_write_data,
                   rf_reg_write, done, result, zero, carry, illegal}),
              32'h4000_0000);
        check("reset_ready_halt_inst", 32'(h_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 26; i++) send(vt[i], 1'b1);
        drain();

        // Illegal opcode on the halting instance parks it until reset.
        @(negedge clock);
        h_valid = 1'b1;
        h_instr = 16'hC000;
        @(posedge clock);
        #1;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!h_done && w < 10);
        check("halt_done", 32'(h_done), 32'd1);
        @(negedge clock);
        check("halt_illegal", 32'(h_illegal), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (h_ready || h_reg_write) seen = 1'b1;
        end
        check("halt_ready_low", 32'(seen), 32'd0);
        h_valid = 1'b0;

        // Reset mid-WB of LI r4,0x55: write must be aborted.
        send(mk(li(3'd4, 8'h55), 8'h55, 0, 0, 0, 1, 1, 3), 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("wb_reached", 32'(rf_reg_write), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_reg_write", 32'(rf_reg_write), 32'd0);
        check("abort_outputs",
              32'({instr_ready, rf_read1, rf_read2, rf_write_reg, rf_write_data,
                   rf_reg_write, done, result, zero, carry, illegal}),
              32'h4000_0000);
        @(posedge clock);
        #1;
        check("r4_unchanged", 32'(rf[4]), 32'h81);
        check("halt_cleared", 32'(h_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        send(mk(enc(4'h1, 3, 4, 0), 8'h81, 0, 0, 0, 1, 1, 3), 1'b1);
        drain();

        check("r0_still_zero", 32'(rf[0]), 32'd0);
        check("r6_shr", 32'(rf[6]), 32'h01);
        check("r3_final", 32'(rf[3]), 32'h81);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
